// File: rtl/prefix_subtractor_pipe.sv
// Two-stage pipelined subtractor: diff = a - b - borrow_in.
// The subtraction runs as a + ~b + ~borrow_in on a Kogge-Stone prefix network.
// The first SPLIT prefix levels run before the stage-1 register and the rest
// run after it. Both stages use valid/ready handshakes. Result fields only
// load when a valid beat moves into them, so they hold steady while idle.
module prefix_subtractor_pipe #(
    parameter int WIDTH = 32,
    parameter int SPLIT = $clog2(WIDTH) / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    localparam int LEVELS = $clog2(WIDTH);

    // Applies prefix levels lo..hi-1 to a (G,P) vector and returns {G, P}.
    // Bits are walked from the top down, so each update still reads the
    // previous level's value at i - 2^k.
    function automatic logic [2*WIDTH-1:0] ks_levels(
        input logic [WIDTH-1:0] g_in,
        input logic [WIDTH-1:0] p_in,
        input int               lo,
        input int               hi
    );
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        g = g_in;
        p = p_in;
        for (int k = lo; k < hi; k++) begin
            for (int i = WIDTH - 1; i >= (1 << k); i--) begin
                g[i] = g[i] | (p[i] & g[i - (1 << k)]);
                p[i] = p[i] & p[i - (1 << k)];
            end
        end
        return {g, p};
    endfunction

    // ---------------- handshake ----------------
    logic r_s1_valid;
    logic r_out_valid;
    logic w_s1_adv;
    logic w_s2_adv;

    assign w_s2_adv = ~r_out_valid | out_ready;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;
    assign in_ready = w_s1_adv;

    // ---------------- stage 1 (combinational) ----------------
    logic [WIDTH-1:0] w_bn;
    logic [WIDTH-1:0] w_p0;
    logic [WIDTH-1:0] w_g0;
    logic [WIDTH-1:0] w_g1;
    logic [WIDTH-1:0] w_p1;

    assign w_bn = ~b;
    assign w_p0 = a ^ w_bn;
    assign w_g0 = a & w_bn;
    assign {w_g1, w_p1} = ks_levels(w_g0, w_p0, 0, SPLIT);

    // ---------------- stage-1 registers ----------------
    logic [WIDTH-1:0] r_s1_p;   // per-bit propagate, needed for the sum bits
    logic [WIDTH-1:0] r_s1_g;   // partial group generate
    logic [WIDTH-1:0] r_s1_gp;  // partial group propagate
    logic             r_s1_c0;
    logic             r_s1_amsb;
    logic             r_s1_bmsb;

    // Stage-1 valid: refilled whenever stage 1 can advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_s1_valid <= 1'b0;
        else if (w_s1_adv) r_s1_valid <= in_valid;
    end

    // Stage-1 data: captured only for a real input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_p    <= '0;
            r_s1_g    <= '0;
            r_s1_gp   <= '0;
            r_s1_c0   <= 1'b0;
            r_s1_amsb <= 1'b0;
            r_s1_bmsb <= 1'b0;
        end else if (w_s1_adv && in_valid) begin
            r_s1_p    <= w_p0;
            r_s1_g    <= w_g1;
            r_s1_gp   <= w_p1;
            r_s1_c0   <= ~borrow_in;
            r_s1_amsb <= a[WIDTH-1];
            r_s1_bmsb <= b[WIDTH-1];
        end
    end

    // ---------------- stage 2 (combinational) ----------------
    logic [WIDTH-1:0] w_g2;
    logic [WIDTH-1:0] w_p2;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_diff;
    logic             w_borrow;
    logic             w_ovf;
    logic             w_zero;

    assign {w_g2, w_p2} = ks_levels(r_s1_g, r_s1_gp, SPLIT, LEVELS);

    // c_i = G[i-1:0] | P[i-1:0] & c_0, with c_0 = ~borrow_in.
    assign w_c      = {w_g2 | (w_p2 & {WIDTH{r_s1_c0}}), r_s1_c0};
    assign w_diff   = r_s1_p ^ w_c[WIDTH-1:0];
    assign w_borrow = ~w_c[WIDTH];
    assign w_ovf    = (r_s1_amsb ^ r_s1_bmsb) & (w_diff[WIDTH-1] ^ r_s1_amsb);
    assign w_zero   = ~|w_diff;

    // ---------------- output registers ----------------
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_ovf;
    logic             r_zero;

    // Output valid: follows stage 1 whenever the output stage can advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_out_valid <= 1'b0;
        else if (w_s2_adv) r_out_valid <= r_s1_valid;
    end

    // Result fields: load only with a valid beat, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_s2_adv && r_s1_valid) begin
            r_diff   <= w_diff;
            r_borrow <= w_borrow;
            r_ovf    <= w_ovf;
            r_zero   <= w_zero;
        end
    end

    assign out_valid  = r_out_valid;
    assign diff       = r_diff;
    assign borrow_out = r_borrow;
    assign overflow   = r_ovf;
    assign zero       = r_zero;

endmodule

// File: tb/tb_prefix_subtractor_pipe.sv
// Bench for prefix_subtractor_pipe (WIDTH=32). It has three parts:
// - table vectors with hand-computed results,
// - directed sequences for streaming, stall, reset and latency,
// - random traffic scored against a 33-bit reference model.
module tb_prefix_subtractor_pipe;

    typedef struct packed {
        logic [31:0] d;
        logic        bo;
        logic        ov;
        logic        z;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bi;
        res_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        borrow_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        borrow_out;
    logic        overflow;
    logic        zero;

    prefix_subtractor_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .borrow_in(borrow_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow_out(borrow_out), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    res_t q[$];
    int   n_vec = 0;
    int   n_mis = 0;
    logic last_acc;
    logic last_rdy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic bi);
        logic [32:0] w;
        res_t        r;
        w    = {1'b0, x} - {1'b0, y} - {32'b0, bi};
        r.d  = w[31:0];
        r.bo = w[32];
        r.ov = (x[31] != y[31]) && (w[31] != x[31]);
        r.z  = (w[31:0] == 32'd0);
        return r;
    endfunction

    task automatic pop_check();
        res_t e;
        if (q.size() == 0) begin
            chk("unexpected_out", 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            chk("diff", diff, e.d);
            chk("borrow_out", {31'b0, borrow_out}, {31'b0, e.bo});
            chk("overflow", {31'b0, overflow}, {31'b0, e.ov});
            chk("zero", {31'b0, zero}, {31'b0, e.z});
        end
    endtask

    // One cycle. Inputs are driven at the negedge and the handshakes are
    // evaluated once they settle. Control returns at the next negedge.
    task automatic cyc(input logic v, input logic [31:0] ta, input logic [31:0] tb,
                       input logic tbi, input logic rdy, input res_t e);
        in_valid = v; a = ta; b = tb; borrow_in = tbi; out_ready = rdy;
        #1;
        last_rdy = in_ready;
        last_acc = in_valid && in_ready;
        if (out_valid && !out_ready && q.size() != 0) chk("stall_hold", diff, q[0].d);
        if (out_valid && out_ready) pop_check();
        if (last_acc) q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 32'd0, 32'd0, 1'b0, rdy, '0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            idle(1'b1);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 32'd0);
        q.delete();
    endtask

    vec_t        tbl[8];
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rbi;
    logic        rv;
    int          acc;
    int          cycles;

    initial begin
        // {a, b, borrow_in, {diff, borrow_out, overflow, zero}}
        tbl[0] = '{32'd5,        32'd3,        1'b0, '{32'h00000002, 1'b0, 1'b0, 1'b0}};
        tbl[1] = '{32'd3,        32'd5,        1'b0, '{32'hFFFFFFFE, 1'b1, 1'b0, 1'b0}};
        tbl[2] = '{32'd7,        32'd7,        1'b0, '{32'h00000000, 1'b0, 1'b0, 1'b1}};
        tbl[3] = '{32'h80000000, 32'd1,        1'b0, '{32'h7FFFFFFF, 1'b0, 1'b1, 1'b0}};
        tbl[4] = '{32'd0,        32'd0,        1'b1, '{32'hFFFFFFFF, 1'b1, 1'b0, 1'b0}};
        tbl[5] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, '{32'h80000000, 1'b1, 1'b1, 1'b0}};
        tbl[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, '{32'hFFFFFFFF, 1'b1, 1'b0, 1'b0}};
        tbl[7] = '{32'd1,        32'd0,        1'b1, '{32'h00000000, 1'b0, 1'b0, 1'b1}};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; borrow_in = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_diff", diff, 32'd0);
        chk("rst_flags", {29'b0, borrow_out, overflow, zero}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors, applied back to back.
        for (int i = 0; i < 8; i++) cyc(1'b1, tbl[i].a, tbl[i].b, tbl[i].bi, 1'b1, tbl[i].e);
        drain();

        // Streaming: 8 beats with no backpressure.
        for (int i = 0; i < 8; i++) begin
            ra = $urandom; rb = $urandom; rbi = 1'($urandom_range(0, 1));
            cyc(1'b1, ra, rb, rbi, 1'b1, model(ra, rb, rbi));
            chk("stream_in_ready", {31'b0, last_rdy}, 32'd1);
        end
        drain();

        // Stall for 4 cycles: two beats are buffered, then in_ready drops.
        for (int i = 0; i < 4; i++) begin
            ra = $urandom; rb = $urandom; rbi = 1'($urandom_range(0, 1));
            cyc(1'b1, ra, rb, rbi, 1'b0, model(ra, rb, rbi));
            chk("stall_in_ready", {31'b0, last_rdy}, (i < 2) ? 32'd1 : 32'd0);
        end
        chk("stall_buffered", q.size(), 32'd2);
        drain();

        // Reset with both stages full; the outputs clear without any clock edge.
        for (int i = 0; i < 2; i++) begin
            ra = $urandom | 32'h1; rb = 32'd0;
            cyc(1'b1, ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0));
        end
        chk("full_out_valid", {31'b0, out_valid}, 32'd1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_diff", diff, 32'd0);
        chk("midrst_flags", {29'b0, borrow_out, overflow, zero}, 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Latency: 10 - 4 is visible after the second edge.
        cyc(1'b1, 32'd10, 32'd4, 1'b0, 1'b1, '{32'd6, 1'b0, 1'b0, 1'b0});
        chk("post_rst_accept", {31'b0, last_acc}, 32'd1);
        chk("lat_edge1_valid", {31'b0, out_valid}, 32'd0);
        idle(1'b1);
        chk("lat_edge2_valid", {31'b0, out_valid}, 32'd1);
        chk("lat_edge2_diff", diff, 32'd6);
        drain();

        // Random traffic: each beat is held until it is accepted.
        acc = 0; cycles = 0;
        ra = $urandom; rb = $urandom; rbi = 1'($urandom_range(0, 1));
        while (acc < 10000 && cycles < 60000) begin
            rv = ($urandom_range(0, 3) != 0);
            cyc(rv, ra, rb, rbi, ($urandom_range(0, 3) != 0), model(ra, rb, rbi));
            if (last_acc) begin
                acc++;
                ra = $urandom; rb = $urandom; rbi = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 15) == 0) rb = ra;
            end
            cycles++;
        end
        if (acc < 10000) chk("random_timeout", acc, 32'd10000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
